ram_port_arbiter: RTL and testbench

//  Shares the single-port unified RAM between instruction fetch (IF) and the MEM stage.

---
 rtl/ram_port_arbiter_pkg.sv | 18 +
 rtl/ram_arb_starve_cnt.sv | 32 +++
 rtl/ram_port_arbiter.sv | 105 ++++++++++
 tb/tb_ram_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-RAM port arbiter.
//   owner_t : identifies which master owns the RAM command (none, IF, MEM).
//   DATA_W  : RAM data width.
//   SEL_W   : byte-enable width.
//   CNT_W   : width of the IF starvation counter.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_IF   = 2'b01,
        OWNER_MEM  = 2'b10
    } owner_t;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Saturating counter of consecutive MEM grants taken while IF was waiting.
//   clk, rst : clock, synchronous active-high reset
//   inc      : MEM granted while IF eligible
//   clr      : IF granted or IF not requesting (wins over inc)
//   at_max   : counter has reached MAX; IF must win the next contest
module ram_arb_starve_cnt
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_C)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port unified RAM between instruction fetch (IF) and
// the MEM stage. MEM has priority; IF is guaranteed a grant after at most
// STARVE_MAX consecutive MEM grants. Acks and read data return one cycle
// after the command is issued to the RAM.
//   if_*   : IF read master (req/addr in, rdata/ack/stall out)
//   mem_*  : MEM read/write master (req/we/sel/addr/wdata in, rdata/ack/stall out)
//   ram_*  : RAM command outputs, ram_rdata input (valid the cycle after a read)
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_stall,

    output logic              ram_ce,
    output logic              ram_we,
    output logic [SEL_W-1:0]  ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    owner_t inflight;
    logic   inflight_we;
    logic   if_elig;
    logic   mem_elig;
    logic   grant_if;
    logic   grant_mem;
    logic   at_max;

    // A port whose previous command is being acked this cycle must not re-issue.
    assign if_elig  = if_req  && (inflight != OWNER_IF);
    assign mem_elig = mem_req && (inflight != OWNER_MEM);

    // Nothing is issued while reset is held, so no write can slip out and
    // the first grant lands on the cycle after reset falls.
    assign grant_mem = !rst && mem_elig && !(at_max && if_elig);
    assign grant_if  = !rst && if_elig && !grant_mem;

    ram_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (grant_mem && if_elig),
        .clr    (grant_if || !if_req),
        .at_max (at_max)
    );

    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_sel   = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_mem) begin
            ram_ce    = 1'b1;
            ram_we    = mem_we;
            ram_sel   = mem_sel;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata;
        end else if (grant_if) begin
            ram_ce    = 1'b1;
            ram_sel   = '1;
            ram_addr  = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight    <= OWNER_NONE;
            inflight_we <= 1'b0;
        end else begin
            inflight    <= grant_mem ? OWNER_MEM : (grant_if ? OWNER_IF : OWNER_NONE);
            inflight_we <= grant_mem && mem_we;
        end
    end

    // Acks are masked while reset is held so an access caught by reset is
    // dropped without ever being acknowledged.
    assign if_ack    = !rst && (inflight == OWNER_IF);
    assign mem_ack   = !rst && (inflight == OWNER_MEM);
    assign if_rdata  = if_ack ? ram_rdata : '0;
    assign mem_rdata = (mem_ack && !inflight_we) ? ram_rdata : '0;
    assign if_stall  = if_req && !if_ack;
    assign mem_stall = mem_req && !mem_ack;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed IF/MEM transactions push
// their expected read data into per-port queues; a monitor compares on acks.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [9:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_stall;
    logic        ram_ce;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int max_cnt     = 0;

    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] ram[0:1023];

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_stall (mem_stall),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_sel   (ram_sel),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM model: read data valid the cycle after the command; garbage otherwise
    // so any ungated data path shows up.
    always @(posedge clk) begin
        if (ram_ce && !ram_we) begin
            ram_rdata <= ram[ram_addr];
        end else begin
            ram_rdata <= 32'hBAD0BAD0;
        end
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        chk("if_stall", {31'd0, if_stall}, {31'd0, if_req & ~if_ack});
        chk("mem_stall", {31'd0, mem_stall}, {31'd0, mem_req & ~mem_ack});
        if (if_ack) begin
            if (if_q.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
            else chk("if_rdata", if_rdata, if_q.pop_front());
        end else begin
            chk("if_rdata_idle", if_rdata, 32'd0);
        end
        if (mem_ack) begin
            if (mem_q.size() == 0) chk("mem_ack_unexpected", 32'd1, 32'd0);
            else chk("mem_rdata", mem_rdata, mem_q.pop_front());
        end else begin
            chk("mem_rdata_idle", mem_rdata, 32'd0);
        end
        if (32'(dut.u_starve.cnt) > max_cnt) max_cnt = 32'(dut.u_starve.cnt);
    end

    // Issue one IF read; lat = cycles spent stalled before the ack cycle.
    task automatic do_if(input logic [9:0] addr, input logic [31:0] exp, output int lat);
        if_q.push_back(exp);
        if_req  = 1'b1;
        if_addr = addr;
        lat = 0;
        forever begin
            @(negedge clk);
            if (if_ack) break;
            lat++;
            if (lat > 50) begin
                chk("if_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [3:0] sel, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, output int lat);
        mem_q.push_back(exp);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_sel   = sel;
        mem_addr  = addr;
        mem_wdata = wdata;
        lat = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) break;
            lat++;
            if (lat > 50) begin
                chk("mem_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4; i++) ram[i] = 32'h34011100 + i;
        ram[5] = 32'h11223344;

        mem_req = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_wdata = 0;

        // 1. Reset held 10 cycles with IF requesting
        rst = 1'b1; if_req = 1'b1; if_addr = 10'd0;
        if_q.push_back(32'h34011100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_ram_ce", {31'd0, ram_ce}, 32'd0);
            chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant_ce", {31'd0, ram_ce}, 32'd1);
        chk("first_grant_sel", {28'd0, ram_sel}, 32'hF);
        chk("first_grant_wdata", ram_wdata, 32'd0);
        chk("first_grant_no_ack", {31'd0, if_ack}, 32'd0);
        @(negedge clk);
        chk("first_ack", {31'd0, if_ack}, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Idle: all RAM outputs zero
        @(negedge clk);
        chk("idle_ce", {31'd0, ram_ce}, 32'd0);
        chk("idle_cmd", {21'd0, ram_we, ram_sel, ram_addr}, 32'd0);
        chk("idle_wdata", ram_wdata, 32'd0);
        @(posedge clk); #1;

        // 2. IF only, back to back
        for (int i = 0; i < 4; i++) begin
            do_if(10'(i), 32'h34011100 + 32'(i), l);
            chk("if_only_lat", 32'(l), 32'd1);
        end

        // 3. MEM byte write then read back
        do_mem(1'b1, 4'b0011, 10'd5, 32'hAABBCCDD, 32'd0, l);
        chk("mem_wr_lat", 32'(l), 32'd1);
        do_mem(1'b0, 4'b1111, 10'd5, 32'h0, 32'h1122CCDD, l);
        chk("mem_rd_lat", 32'(l), 32'd1);

        // 4. Continuous IF and MEM traffic
        fork
            begin
                int li;
                for (int i = 0; i < 8; i++) begin
                    do_if(10'(i % 4), 32'h34011100 + 32'(i % 4), li);
                    chk("contend_if_wait", {31'd0, li <= 10}, 32'd1);
                end
            end
            begin
                int lm;
                for (int j = 0; j < 8; j++) begin
                    do_mem(1'b1, 4'hF, 10'(20 + j), 32'(j), 32'd0, lm);
                    chk("contend_mem_wait", {31'd0, lm <= 2}, 32'd1);
                end
            end
        join
        chk("starve_cnt_bound", {31'd0, max_cnt <= 4}, 32'd1);

        // 5. Same-cycle MEM write and IF read to addr 7: MEM first
        fork
            begin
                int lm5;
                do_mem(1'b1, 4'hF, 10'd7, 32'hDEADBEEF, 32'd0, lm5);
                chk("same_addr_mem_lat", 32'(lm5), 32'd1);
            end
            begin
                int li5;
                do_if(10'd7, 32'hDEADBEEF, li5);
                chk("same_addr_if_lat", 32'(li5), 32'd2);
            end
        join

        // 6. Reset while a MEM read is in flight
        mem_q.push_back(32'h1122CCDD);
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 10'd5;
        @(negedge clk);
        chk("rst6_issue_ce", {31'd0, ram_ce}, 32'd1);
        chk("rst6_issue_addr", {22'd0, ram_addr}, 32'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst6_no_ack", {31'd0, mem_ack}, 32'd0);
        chk("rst6_no_issue", {31'd0, ram_ce}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst6_inflight_none", {30'd0, 2'(dut.inflight)}, 32'd0);
        @(negedge clk);
        chk("rst6_still_no_ack", {31'd0, mem_ack}, 32'd0);
        chk("rst6_reissue_ce", {31'd0, ram_ce}, 32'd1);
        @(negedge clk);
        chk("rst6_ack", {31'd0, mem_ack}, 32'd1);
        @(posedge clk); #1;
        mem_req = 1'b0;

        repeat (3) @(posedge clk);
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
